// File: rtl/nlfsr_period_tester.sv
// nlfsr_period_tester
//    One worker of the NLFSR search array. It loads tap coefficients from the shared
//    coefficient PRNG and builds a SIZE-bit nonlinear feedback shift register from
//    them. It then clocks that register from seed 1 and reports whether the period
//    is maximal (2^SIZE-1).
// Ports
//    clk         system clock, all logic on the rising edge
//    res         synchronous active-high reset
//    ena         start request (level, sampled while idle/done)
//    take_coef   shared strobe, coef is valid this cycle
//    coef        coefficient byte from the shared PRNG
//    co_buf_lin  linear tap mask of the current job (bit k = tap k used)
//    ready       1 = idle or finished, a job can be accepted
//    failure     1 = job done, period not maximal
//    found       1 = job done, period is maximal
module nlfsr_period_tester #(
   parameter int SIZE        = 24,
   parameter int NUM_OF_TAPS = 6
) (
   input  logic            clk,
   input  logic            res,
   input  logic            ena,
   input  logic            take_coef,
   input  logic [7:0]      coef,
   output logic [SIZE-1:0] co_buf_lin,
   output logic            ready,
   output logic            failure,
   output logic            found
);

   localparam int TW = $clog2(SIZE);
   localparam int CW = $clog2(NUM_OF_TAPS + 1);
   localparam logic [CW-1:0]   IDX_P     = CW'(NUM_OF_TAPS - 2);
   localparam logic [CW-1:0]   IDX_Q     = CW'(NUM_OF_TAPS - 1);
   localparam logic [SIZE-1:0] SEED      = SIZE'(1);
   localparam logic [SIZE-1:0] FULL_CNT  = {SIZE{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Feedback bit. The s[0] term keeps the state map invertible, so the seed always recurs.
   function automatic logic nlfsr_feedback(input logic [SIZE-1:0] s,
                                           input logic [SIZE-1:0] mask,
                                           input logic [TW-1:0]   p,
                                           input logic [TW-1:0]   q);
      logic and_term;
      and_term = 1'b0;
      if (p != q) begin
         and_term = s[p] & s[q];
      end else begin
         and_term = 1'b0;
      end
      return s[0] ^ (^(s & mask)) ^ and_term;
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   logic              ready_nxt_s;
   logic [CW-1:0]     tap_cnt_r;
   logic [TW-1:0]     p_r;
   logic [TW-1:0]     q_r;
   logic [SIZE-1:0]   mask_r;
   logic [SIZE-1:0]   s_r;
   logic [SIZE-1:0]   cnt_r;
   logic              found_r;
   logic              failure_r;
   logic              ready_r;

   logic [TW-1:0]     tap_s;
   logic [SIZE-1:0]   s_nxt_s;
   logic [SIZE-1:0]   cnt_inc_s;
   logic              seed_hit_s;
   logic              full_s;
   logic              run_end_s;

   // Tap mapping and one RUN step of the register.
   always_comb begin
      tap_s      = TW'((32'(coef) % 32'(SIZE - 1)) + 32'd1);
      s_nxt_s    = {nlfsr_feedback(s_r, mask_r, p_r, q_r), s_r[SIZE-1:1]};
      cnt_inc_s  = cnt_r + SIZE'(1);
      seed_hit_s = (s_nxt_s == SEED);
      full_s     = (cnt_inc_s == FULL_CNT);
      // Reaching the full count ends the job even without a seed return.
      run_end_s  = seed_hit_s | full_s;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (res) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (ena) state_nxt_s = ST_LOAD;
            else     state_nxt_s = state_r;
         end
         ST_LOAD: begin
            if (take_coef && (tap_cnt_r == IDX_Q)) state_nxt_s = ST_RUN;
            else                                   state_nxt_s = ST_LOAD;
         end
         ST_RUN: begin
            if (run_end_s) state_nxt_s = ST_DONE;
            else           state_nxt_s = ST_RUN;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode: ready is registered from the upcoming state.
   always_comb begin
      ready_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_IDLE, ST_DONE: ready_nxt_s = 1'b1;
         default:          ready_nxt_s = 1'b0;
      endcase
   end

   // Datapath: tap capture, register stepping, result flags.
   always_ff @(posedge clk) begin
      if (res) begin
         tap_cnt_r <= '0;
         p_r       <= '0;
         q_r       <= '0;
         mask_r    <= '0;
         s_r       <= '0;
         cnt_r     <= '0;
         found_r   <= 1'b0;
         failure_r <= 1'b0;
         ready_r   <= 1'b1;
      end else begin
         ready_r <= ready_nxt_s;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (ena) begin
                  found_r   <= 1'b0;
                  failure_r <= 1'b0;
                  mask_r    <= '0;
                  tap_cnt_r <= '0;
               end
            end
            ST_LOAD: begin
               if (take_coef) begin
                  tap_cnt_r <= tap_cnt_r + CW'(1);
                  if (tap_cnt_r < IDX_P) begin
                     mask_r <= mask_r | (SIZE'(1) << tap_s);
                  end else if (tap_cnt_r == IDX_P) begin
                     p_r <= tap_s;
                  end else begin
                     q_r   <= tap_s;
                     s_r   <= SEED;
                     cnt_r <= '0;
                  end
               end
            end
            ST_RUN: begin
               s_r   <= s_nxt_s;
               cnt_r <= cnt_inc_s;
               if (run_end_s) begin
                  found_r   <= seed_hit_s & full_s;
                  failure_r <= seed_hit_s ^ full_s;
               end
            end
            default: begin
               found_r   <= 1'b0;
               failure_r <= 1'b0;
            end
         endcase
      end
   end

   assign co_buf_lin = mask_r;
   assign ready      = ready_r;
   assign found      = found_r;
   assign failure    = failure_r;

endmodule

// File: tb/tb_nlfsr_period_tester.sv
module tb_nlfsr_period_tester;

   localparam int SIZE = 4;
   localparam int NT   = 3;

   logic            clk = 1'b0;
   logic            res;
   logic            ena;
   logic            take_coef;
   logic [7:0]      coef;
   logic [SIZE-1:0] co_buf_lin;
   logic            ready;
   logic            failure;
   logic            found;

   typedef struct {
      logic            found;
      logic            fail;
      int              steps;
      logic [SIZE-1:0] mask;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   nlfsr_period_tester #(.SIZE(SIZE), .NUM_OF_TAPS(NT)) dut (
      .clk        (clk),
      .res        (res),
      .ena        (ena),
      .take_coef  (take_coef),
      .coef       (coef),
      .co_buf_lin (co_buf_lin),
      .ready      (ready),
      .failure    (failure),
      .found      (found)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Independent model: taps from coefs, then walk the register from seed 1.
   function automatic exp_t model(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
      exp_t e;
      int t0, p, q;
      logic [SIZE-1:0] s;
      logic fb;
      t0 = (int'(c0) % (SIZE - 1)) + 1;
      p  = (int'(c1) % (SIZE - 1)) + 1;
      q  = (int'(c2) % (SIZE - 1)) + 1;
      e.mask  = '0;
      e.mask[t0] = 1'b1;
      e.found = 1'b0;
      e.fail  = 1'b0;
      e.steps = 0;
      s = 4'b0001;
      for (int n = 1; n <= 15; n++) begin
         fb = s[0] ^ s[t0] ^ ((p != q) ? (s[p] & s[q]) : 1'b0);
         s  = {fb, s[3:1]};
         if (s == 4'b0001) begin
            e.found = (n == 15);
            e.fail  = (n != 15);
            e.steps = n;
            break;
         end else if (n == 15) begin
            e.fail  = 1'b1;
            e.steps = n;
         end
      end
      return e;
   endfunction

   // Start a job; noisy adds gaps and stray take_coef pulses outside LOAD.
   task automatic start_job(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                            input bit noisy);
      logic [7:0] cs [3];
      cs[0] = c0; cs[1] = c1; cs[2] = c2;
      if (noisy) begin
         take_coef = 1'b1; coef = 8'd1; step();
         step();
      end
      ena = 1'b1;
      take_coef = noisy; coef = 8'd1;
      step();
      ena = 1'b0; take_coef = 1'b0;
      check_eq("accept_ready", 32'(ready), 32'd0);
      check_eq("accept_found_clr", 32'(found), 32'd0);
      check_eq("accept_fail_clr", 32'(failure), 32'd0);
      for (int i = 0; i < 3; i++) begin
         if (noisy) begin
            take_coef = 1'b0; step(); step();
         end
         take_coef = 1'b1; coef = cs[i];
         step();
      end
      take_coef = 1'b0;
   endtask

   // Wait for the result and compare against the scoreboard head.
   task automatic finish_job(input bit noisy);
      int   n;
      exp_t e;
      n = 0;
      while (!(found || failure) && n < 100) begin
         take_coef = noisy; coef = 8'd2;
         step();
         n++;
      end
      take_coef = 1'b0;
      check_eq("done_in_budget", 32'(n < 100), 32'd1);
      e = sb_q.pop_front();
      check_eq("found", 32'(found), 32'(e.found));
      check_eq("failure", 32'(failure), 32'(e.fail));
      check_eq("steps", 32'(n), 32'(e.steps));
      check_eq("mask", 32'(co_buf_lin), 32'(e.mask));
      check_eq("ready_done", 32'(ready), 32'd1);
      step();
      check_eq("hold_found", 32'(found), 32'(e.found));
      check_eq("hold_failure", 32'(failure), 32'(e.fail));
   endtask

   task automatic job(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                      input bit noisy);
      sb_q.push_back(model(c0, c1, c2));
      start_job(c0, c1, c2, noisy);
      finish_job(noisy);
   endtask

   initial begin
      exp_t e1;
      res = 1'b1; ena = 1'b0; take_coef = 1'b0; coef = 8'd0;
      step(); step();
      res = 1'b0;
      check_eq("rst_ready", 32'(ready), 32'd1);
      check_eq("rst_found", 32'(found), 32'd0);
      check_eq("rst_failure", 32'(failure), 32'd0);
      check_eq("rst_mask", 32'(co_buf_lin), 32'd0);

      // Spec-fixed constants for the two LFSR cases, independent of the model.
      e1 = model(8'd0, 8'd0, 8'd0);
      check_eq("model_t1_steps", 32'(e1.steps), 32'd15);
      check_eq("model_t1_found", 32'(e1.found), 32'd1);
      e1 = model(8'd1, 8'd0, 8'd0);
      check_eq("model_t2_steps", 32'(e1.steps), 32'd6);

      job(8'd0, 8'd0, 8'd0, 1'b0);     // maximal x^4+x+1
      job(8'd1, 8'd0, 8'd0, 1'b0);     // period 6
      job(8'd0, 8'd0, 8'd0, 1'b1);     // stray strobes and gaps
      job(8'd0, 8'd0, 8'd1, 1'b0);     // AND term active
      job(8'd5, 8'd3, 8'd7, 1'b0);     // taps 3, p=1, q=2

      // Abort mid-RUN with reset, then restart cleanly.
      start_job(8'd0, 8'd0, 8'd0, 1'b0);
      repeat (5) step();
      check_eq("run_busy", 32'(ready), 32'd0);
      res = 1'b1; step(); res = 1'b0;
      check_eq("abort_ready", 32'(ready), 32'd1);
      check_eq("abort_found", 32'(found), 32'd0);
      check_eq("abort_failure", 32'(failure), 32'd0);
      check_eq("abort_mask", 32'(co_buf_lin), 32'd0);
      repeat (20) step();
      check_eq("abort_no_pulse", 32'(found | failure), 32'd0);
      job(8'd0, 8'd0, 8'd0, 1'b0);

      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
